// File: rtl/axi_read_arbiter_rr_if.sv
// Read-path bundle for axi_read_arbiter_rr.
// slave modport : arbiter side facing the N cache read masters (m_* signals).
// master modport: arbiter side facing the downstream AXI read channel (s_* signals).
interface axi_read_arbiter_rr_if #(
  parameter int unsigned MASTERS    = 4,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned LEN_WIDTH  = 4
);
  // upstream (per-master) side
  logic [MASTERS-1:0]            m_arvalid;
  logic [MASTERS-1:0]            m_arready;
  logic [MASTERS*ADDR_WIDTH-1:0] m_araddr;
  logic [MASTERS*LEN_WIDTH-1:0]  m_arlen;
  logic [MASTERS-1:0]            m_rvalid;
  logic [MASTERS-1:0]            m_rready;
  logic [DATA_WIDTH-1:0]         m_rdata;
  logic                          m_rlast;

  // downstream AXI read side
  logic                  s_arvalid;
  logic                  s_arready;
  logic [ID_WIDTH-1:0]   s_arid;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [LEN_WIDTH-1:0]  s_arlen;
  logic                  s_rvalid;
  logic                  s_rready;
  logic [ID_WIDTH-1:0]   s_rid;
  logic                  s_rlast;
  logic [DATA_WIDTH-1:0] s_rdata;

  modport slave (
    input  m_arvalid, m_araddr, m_arlen, m_rready,
    output m_arready, m_rvalid, m_rdata, m_rlast
  );

  modport master (
    output s_arvalid, s_arid, s_araddr, s_arlen, s_rready,
    input  s_arready, s_rvalid, s_rid, s_rlast, s_rdata
  );
endinterface

// File: rtl/axi_read_arbiter_rr.sv
// N-master read arbiter onto one AXI-style read channel, one burst in flight.
// Grants round-robin (or fixed lowest-index priority when ARB_FIXED_PRIORITY_EN
// is defined), tags ARID with the master index and steers R beats back by RID.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   up (slave)  : per-master AR request/accept and R beat delivery
//   dn (master) : downstream AR channel and R channel
//   busy        : FSM not idle
//   grant_idx   : current or last granted master
//   err_sticky  : RID mismatch / beat-count violation seen since reset
module axi_read_arbiter_rr #(
  parameter int unsigned MASTERS    = 4,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  axi_read_arbiter_rr_if.slave        up,
  axi_read_arbiter_rr_if.master       dn,
  output logic                        busy,
  output logic [$clog2(MASTERS)-1:0]  grant_idx,
  output logic                        err_sticky
);
  localparam int unsigned IDX_W = $clog2(MASTERS);
  localparam int unsigned CNT_W = LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  req_found;
  logic [IDX_W-1:0]      req_sel;
  logic                  rid_match;

  logic [MASTERS-1:0]    arready_c;
  logic [MASTERS-1:0]    rvalid_c;
  logic                  rready_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  rlast_c;
  logic                  arvalid_c;

`ifdef ARB_FIXED_PRIORITY_EN
  // Lowest-index active requester wins; downward scan lets the lowest write last.
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    for (int unsigned k = MASTERS; k > 0; k--) begin
      if (up.m_arvalid[IDX_W'(k - 1)]) begin
        req_found = 1'b1;
        req_sel   = IDX_W'(k - 1);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] rr_idx;

  // First requester scanning upward from rr_ptr+1 with wrap.
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    rr_idx    = '0;
    for (int unsigned k = 0; k < MASTERS; k++) begin
      rr_idx = IDX_W'((32'(rr_ptr_q) + 32'd1 + k) % MASTERS);
      if (!req_found && up.m_arvalid[rr_idx]) begin
        req_found = 1'b1;
        req_sel   = rr_idx;
      end
    end
  end
`endif

  // Next-state and channel steering.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
`ifndef ARB_FIXED_PRIORITY_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    arready_c = '0;
    rvalid_c  = '0;
    rready_c  = 1'b0;
    rdata_c   = '0;
    rlast_c   = 1'b0;
    arvalid_c = 1'b0;
    rid_match = (dn.s_rid == ID_WIDTH'(gnt_q));

    unique case (state_q)
      IDLE: begin
        if (req_found) begin
          arready_c[req_sel] = 1'b1;
          gnt_d   = req_sel;
          addr_d  = up.m_araddr[32'(req_sel) * ADDR_WIDTH +: ADDR_WIDTH];
          len_d   = up.m_arlen[32'(req_sel) * LEN_WIDTH +: LEN_WIDTH];
`ifndef ARB_FIXED_PRIORITY_EN
          rr_ptr_d = req_sel;
`endif
          state_d = ADDR;
        end
      end
      ADDR: begin
        arvalid_c = 1'b1;
        if (dn.s_arready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (rid_match) begin
          rvalid_c[gnt_q] = dn.s_rvalid;
          rready_c        = up.m_rready[gnt_q];
          rdata_c         = dn.s_rdata;
          rlast_c         = dn.s_rlast;
          if (dn.s_rvalid && up.m_rready[gnt_q]) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dn.s_rlast) begin
              // early rlast still closes the burst
              if (cnt_q < CNT_W'(len_q)) err_d = 1'b1;
              state_d = IDLE;
            end else if (cnt_q == CNT_W'(len_q)) begin
              err_d = 1'b1;
            end
          end
        end else begin
          // foreign RID: swallow the beat so the channel cannot wedge
          rready_c = 1'b1;
          if (dn.s_rvalid) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_ptr_q <= IDX_W'(MASTERS - 1);
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Every output, registered or combinational, reads 0 while rst is high.
  assign up.m_arready = rst ? '0 : arready_c;
  assign up.m_rvalid  = rst ? '0 : rvalid_c;
  assign up.m_rdata   = rst ? '0 : rdata_c;
  assign up.m_rlast   = !rst && rlast_c;
  assign dn.s_arvalid = !rst && arvalid_c;
  assign dn.s_arid    = rst ? '0 : ID_WIDTH'(gnt_q);
  assign dn.s_araddr  = rst ? '0 : addr_q;
  assign dn.s_arlen   = rst ? '0 : len_q;
  assign dn.s_rready  = !rst && rready_c;
  assign busy         = !rst && (state_q != IDLE);
  assign grant_idx    = rst ? '0 : gnt_q;
  assign err_sticky   = !rst && err_q;
endmodule

// File: tb/tb_axi_read_arbiter_rr.sv
module tb_axi_read_arbiter_rr;
  localparam int unsigned MASTERS = 4;
  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned LW = 4;

  typedef struct { logic [IW-1:0] id; logic [AW-1:0] addr; logic [LW-1:0] len; } ar_t;
  typedef struct { int m; logic [DW-1:0] d; logic last; } beat_t;

  logic clk;
  logic rst;
  logic busy;
  logic [1:0] grant_idx;
  logic err_sticky;

  axi_read_arbiter_rr_if #(.MASTERS(MASTERS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                           .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

  axi_read_arbiter_rr #(.MASTERS(MASTERS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .ID_WIDTH(IW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .up(bus), .dn(bus),
    .busy(busy), .grant_idx(grant_idx), .err_sticky(err_sticky)
  );

  int n_cmp;
  int n_fail;
  int exp_grant[$];
  ar_t exp_ar[$];
  beat_t exp_beat[$];
  bit tog_en;
  int tog_cnt;
  logic [3:0] tog_pat;
  int ord2[6];
  int ord7[5];
  logic [AW-1:0] a7[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event with no matching expectation or timeout", name);
  endtask

  task automatic push_grant(input int g);
    exp_grant.push_back(g);
  endtask

  task automatic push_ar(input int id, input logic [AW-1:0] a, input logic [LW-1:0] l);
    ar_t t;
    t.id = IW'(id); t.addr = a; t.len = l;
    exp_ar.push_back(t);
  endtask

  task automatic push_beat(input int m, input logic [DW-1:0] d, input logic last);
    beat_t b;
    b.m = m; b.d = d; b.last = last;
    exp_beat.push_back(b);
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic [LW-1:0] l);
    bus.m_araddr[m*AW +: AW] = a;
    bus.m_arlen[m*LW +: LW]  = l;
  endtask

  // Scoreboard monitor: pops one expectation per observed output event.
  always @(negedge clk) begin
    int g;
    ar_t a;
    beat_t b;
    if (!rst) begin
      if (bus.m_arready != '0) begin
        if (exp_grant.size() == 0) fail_now("grant_unexpected");
        else begin
          g = exp_grant.pop_front();
          chk("grant_onehot", 64'(bus.m_arready), 64'(1) << g);
        end
      end
      if (bus.s_arvalid && bus.s_arready) begin
        if (exp_ar.size() == 0) fail_now("ar_unexpected");
        else begin
          a = exp_ar.pop_front();
          chk("s_arid", 64'(bus.s_arid), 64'(a.id));
          chk("s_araddr", 64'(bus.s_araddr), 64'(a.addr));
          chk("s_arlen", 64'(bus.s_arlen), 64'(a.len));
        end
      end
      if ((bus.m_rvalid & bus.m_rready) != '0) begin
        if (exp_beat.size() == 0) fail_now("beat_unexpected");
        else begin
          b = exp_beat.pop_front();
          chk("m_rvalid", 64'(bus.m_rvalid), 64'(1) << b.m);
          chk("m_rdata", 64'(bus.m_rdata), 64'(b.d));
          chk("m_rlast", 64'(bus.m_rlast), 64'(b.last));
        end
      end
    end
  end

  task automatic wait_grant(input int m);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.m_arready[m]) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) fail_now("grant_timeout");
  endtask

  task automatic wait_ar_hs();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.s_arvalid && bus.s_arready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) fail_now("ar_handshake_timeout");
  endtask

  task automatic send_beat(input int rid, input logic [DW-1:0] d, input logic last, input bit drop);
    bit ok;
    ok = 1'b0;
    bus.s_rvalid = 1'b1; bus.s_rid = IW'(rid); bus.s_rdata = d; bus.s_rlast = last;
    for (int n = 0; n < 40; n++) begin
      if (tog_en) begin
        bus.m_rready[1] = tog_pat[tog_cnt % 4];
        tog_cnt++;
      end
      @(negedge clk);
      if (tog_en) chk("s_rready_mirror", 64'(bus.s_rready), 64'(bus.m_rready[1]));
      if (drop) chk("dropped_beat_m_rvalid", 64'(bus.m_rvalid), 64'd0);
      if (bus.s_rready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) fail_now("beat_timeout");
    bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; tog_en = 1'b0; tog_cnt = 0; tog_pat = 4'b1001;
`ifdef ARB_FIXED_PRIORITY_EN
    ord2 = '{0, 0, 0, 0, 0, 0};
    ord7 = '{0, 0, 0, 0, 0};
`else
    ord2 = '{0, 1, 2, 3, 0, 1};
    ord7 = '{3, 0, 3, 0, 3};
`endif
    a7 = '{26'h7000, 26'h7100, 26'h7200, 26'h7300};
    bus.m_arvalid = '0; bus.m_araddr = '0; bus.m_arlen = '0; bus.m_rready = '1;
    bus.s_arready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rid = '0; bus.s_rlast = 1'b0;
    bus.s_rdata = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_rready", 64'(bus.s_rready), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_grant_idx", 64'(grant_idx), 64'd0);
    chk("init_err", 64'(err_sticky), 64'd0);
    chk("init_s_arvalid", 64'(bus.s_arvalid), 64'd0);
    chk("init_m_rvalid", 64'(bus.m_rvalid), 64'd0);
    @(posedge clk); #1;

    // single master 2 burst, ADDR held by s_arready=0, stray beat during ADDR
    set_req(2, 26'h0001F0, 4'd3);
    push_grant(2); push_ar(2, 26'h0001F0, 4'd3);
    bus.m_arvalid[2] = 1'b1;
    wait_grant(2);
    bus.m_arvalid[2] = 1'b0;
    bus.s_rvalid = 1'b1; bus.s_rid = 4'd2;
    @(negedge clk);
    chk("addr_s_arvalid", 64'(bus.s_arvalid), 64'd1);
    chk("addr_s_rready", 64'(bus.s_rready), 64'd0);
    chk("addr_m_rvalid", 64'(bus.m_rvalid), 64'd0);
    @(posedge clk); #1 bus.s_rvalid = 1'b0;
    @(negedge clk);
    chk("addr_hold_s_arvalid", 64'(bus.s_arvalid), 64'd1);
    chk("addr_err", 64'(err_sticky), 64'd0);
    chk("addr_busy", 64'(busy), 64'd1);
    chk("addr_grant_idx", 64'(grant_idx), 64'd2);
    @(posedge clk); #1 bus.s_arready = 1'b1;
    wait_ar_hs();
    for (int i = 0; i < 4; i++) push_beat(2, 32'hA0 + 32'(i), i == 3);
    for (int i = 0; i < 4; i++) send_beat(2, 32'hA0 + 32'(i), i == 3, 1'b0);
    @(negedge clk);
    chk("t1_busy_done", 64'(busy), 64'd0);
    chk("t1_err", 64'(err_sticky), 64'd0);
    @(posedge clk); #1;

    // all four requesting, single-beat bursts
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k, 26'h1000 + 26'(k * 256), 4'd0);
    for (int i = 0; i < 6; i++) begin
      push_grant(ord2[i]);
      push_ar(ord2[i], 26'h1000 + 26'(ord2[i] * 256), 4'd0);
      push_beat(ord2[i], 32'hB0 + 32'(i), 1'b1);
    end
    bus.m_arvalid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      wait_ar_hs();
      chk("t2_grant_idx", 64'(grant_idx), 64'(ord2[i]));
      if (i == 5) bus.m_arvalid = '0;
      send_beat(ord2[i], 32'hB0 + 32'(i), 1'b1, 1'b0);
    end

    // master 1 with m_rready[1] toggling 1,0,0,1
    set_req(1, 26'h2220, 4'd3);
    push_grant(1); push_ar(1, 26'h2220, 4'd3);
    for (int i = 0; i < 4; i++) push_beat(1, 32'hC0 + 32'(i), i == 3);
    bus.m_arvalid[1] = 1'b1;
    wait_grant(1);
    bus.m_arvalid[1] = 1'b0;
    wait_ar_hs();
    tog_en = 1'b1; tog_cnt = 0;
    for (int i = 0; i < 4; i++) send_beat(1, 32'hC0 + 32'(i), i == 3, 1'b0);
    tog_en = 1'b0; bus.m_rready = '1;

    // foreign RID during master 0 burst
    set_req(0, 26'h3330, 4'd1);
    push_grant(0); push_ar(0, 26'h3330, 4'd1);
    push_beat(0, 32'hD0, 1'b0); push_beat(0, 32'hD1, 1'b1);
    bus.m_arvalid[0] = 1'b1;
    wait_grant(0);
    bus.m_arvalid[0] = 1'b0;
    wait_ar_hs();
    send_beat(3, 32'hDEAD, 1'b0, 1'b1);
    chk("t4_err_set", 64'(err_sticky), 64'd1);
    chk("t4_still_busy", 64'(busy), 64'd1);
    send_beat(0, 32'hD0, 1'b0, 1'b0);
    send_beat(0, 32'hD1, 1'b1, 1'b0);

    // reset during beat 2 of 4
    set_req(3, 26'h4440, 4'd3);
    push_grant(3); push_ar(3, 26'h4440, 4'd3); push_beat(3, 32'hE0, 1'b0);
    bus.m_arvalid[3] = 1'b1;
    wait_grant(3);
    bus.m_arvalid[3] = 1'b0;
    wait_ar_hs();
    send_beat(3, 32'hE0, 1'b0, 1'b0);
    rst = 1'b1; bus.s_rvalid = 1'b1; bus.s_rid = 4'd3; bus.s_rdata = 32'hE1;
    @(negedge clk);
    chk("inrst_busy", 64'(busy), 64'd0);
    chk("inrst_m_rvalid", 64'(bus.m_rvalid), 64'd0);
    chk("inrst_s_rready", 64'(bus.s_rready), 64'd0);
    chk("inrst_err", 64'(err_sticky), 64'd0);
    @(posedge clk); #1 rst = 1'b0; bus.s_rvalid = 1'b0;
    @(negedge clk);
    chk("postrst_busy", 64'(busy), 64'd0);
    chk("postrst_s_arvalid", 64'(bus.s_arvalid), 64'd0);
    chk("postrst_err", 64'(err_sticky), 64'd0);
    chk("postrst_grant_idx", 64'(grant_idx), 64'd0);
    @(posedge clk); #1;
    set_req(0, 26'h5000, 4'd0); set_req(2, 26'h5200, 4'd0);
    push_grant(0); push_ar(0, 26'h5000, 4'd0); push_beat(0, 32'hF0, 1'b1);
    push_grant(2); push_ar(2, 26'h5200, 4'd0); push_beat(2, 32'hF2, 1'b1);
    bus.m_arvalid = 4'b0101;
    wait_grant(0);
    bus.m_arvalid[0] = 1'b0;
    wait_ar_hs();
    send_beat(0, 32'hF0, 1'b1, 1'b0);
    wait_grant(2);
    bus.m_arvalid[2] = 1'b0;
    wait_ar_hs();
    send_beat(2, 32'hF2, 1'b1, 1'b0);

    // early rlast on first beat of a 3-beat burst
    set_req(1, 26'h6000, 4'd2);
    push_grant(1); push_ar(1, 26'h6000, 4'd2); push_beat(1, 32'h77, 1'b1);
    bus.m_arvalid[1] = 1'b1;
    wait_grant(1);
    bus.m_arvalid[1] = 1'b0;
    wait_ar_hs();
    send_beat(1, 32'h77, 1'b1, 1'b0);
    @(negedge clk);
    chk("early_rlast_err", 64'(err_sticky), 64'd1);
    chk("early_rlast_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // masters 0 and 3 requesting continuously for five bursts
    set_req(0, a7[0], 4'd0); set_req(3, a7[3], 4'd0);
    for (int i = 0; i < 5; i++) begin
      push_grant(ord7[i]);
      push_ar(ord7[i], a7[ord7[i]], 4'd0);
      push_beat(ord7[i], 32'h70 + 32'(i), 1'b1);
    end
    bus.m_arvalid = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      wait_ar_hs();
      chk("t7_grant_idx", 64'(grant_idx), 64'(ord7[i]));
      if (i == 4) bus.m_arvalid = '0;
      send_beat(ord7[i], 32'h70 + 32'(i), 1'b1, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("left_grants", 64'(exp_grant.size()), 64'd0);
    chk("left_ars", 64'(exp_ar.size()), 64'd0);
    chk("left_beats", 64'(exp_beat.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter_rr.md
Name: axi_read_arbiter_rr

Overview:
- Parametrised successor to the core's fixed two-master read arbitration path.
- Arbitrates N read masters (i-cache, d-cache, stream buffer, prefetchers) onto one AXI-style read channel.
- Uses round-robin grant, tags ARID with the master index, and routes R beats back by RID.
- Sits between cache read ports and the external AXI read address/data interface; one burst outstanding at a time.

Parameters:
MASTERS, 4, number of read masters (2..16)
ADDR_WIDTH, 26, byte address width
DATA_WIDTH, 32, data beat width
ID_WIDTH, 4, AXI ID width; must satisfy 2**ID_WIDTH >= MASTERS
LEN_WIDTH, 4, burst length field width (beats = len+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
m_arvalid  in  MASTERS  per-master address request
m_arready  out  MASTERS  per-master address accept, one-hot pulse
m_araddr  in  MASTERS*ADDR_WIDTH  packed addresses, master i at slice i
m_arlen  in  MASTERS*LEN_WIDTH  packed burst lengths
m_rvalid  out  MASTERS  per-master beat valid
m_rready  in  MASTERS  per-master beat ready
m_rdata  out  DATA_WIDTH  broadcast read data
m_rlast  out  1  broadcast last-beat flag
s_arvalid  out  1  downstream address valid
s_arready  in  1  downstream address ready
s_arid  out  ID_WIDTH  master index, zero-extended
s_araddr  out  ADDR_WIDTH  latched address
s_arlen  out  LEN_WIDTH  latched length
s_rvalid  in  1  downstream beat valid
s_rready  out  1  downstream beat ready
s_rid  in  ID_WIDTH  beat ID
s_rlast  in  1  downstream last beat
s_rdata  in  DATA_WIDTH  downstream data
busy  out  1  state != IDLE
grant_idx  out  $clog2(MASTERS)  current or last granted master
err_sticky  out  1  protocol error seen, cleared only by rst

Behaviour:
- Reset values: state=IDLE; s_arvalid=0; m_arready=0; s_rready=0; m_rvalid=0; busy=0; grant_idx=0; err_sticky=0; rr_ptr=MASTERS-1, so master 0 wins first.
- All outputs are forced to 0 while rst=1, including combinational terms.
- FSM IDLE:
  - If any m_arvalid is set, select the first requester scanning from (rr_ptr+1) mod MASTERS upward with wrap.
  - Pulse m_arready[g]=1 that cycle.
  - Latch addr, len and id=g; set grant_idx=g and rr_ptr=g; go to ADDR.
  - With no request, stay in IDLE.
- FSM ADDR:
  - s_arvalid=1 with the latched s_araddr, s_arlen and s_arid.
  - Hold until s_arready; on handshake, clear beat_cnt and go to DATA.
  - Master inputs are ignored in this state.
- FSM DATA:
  - Beat matches when s_rid equals the latched id.
  - On a match: m_rvalid[g]=s_rvalid, s_rready=m_rready[g], m_rdata=s_rdata, m_rlast=s_rlast. Other m_rvalid bits are 0.
  - beat_cnt increments on each accepted beat, wrapping at LEN_WIDTH+1 bits.
  - Accepted beat with s_rlast=1: go to IDLE.
- Latency: request to s_arvalid = 1 cycle. Back-to-back bursts have one IDLE cycle between the last beat and the next grant.
- RID mismatch in DATA:
  - Assert s_rready=1 and drop the beat; no m_rvalid is asserted.
  - Set err_sticky; stay in DATA.
- Beat count overrun: if an accepted beat has beat_cnt==len and s_rlast=0, set err_sticky and continue until rlast.
- Early rlast: an accepted s_rlast with beat_cnt<len sets err_sticky and goes to IDLE.
- Simultaneous requests: only one grant per IDLE cycle; losers keep m_arvalid high and are served in rotation. No starvation: worst-case wait is MASTERS-1 bursts.
- A master dropping m_arvalid before grant simply loses eligibility.
- Reset mid-burst: the FSM returns to IDLE immediately and in-flight downstream beats are not drained. Downstream is reset together with this block.
- s_rvalid seen while in IDLE or ADDR: s_rready=0 and err_sticky is left unchanged.

Optional Feature:
ARB_FIXED_PRIORITY_EN
- Defined: grant goes to the lowest-index active requester; rr_ptr is unused and held at reset value. Master 0 may starve others.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
- Only m_arvalid[2]=1, addr=0x0001F0, len=3 -> m_arready[2] pulses once, then s_arvalid with s_arid=2 and s_araddr=0x0001F0. Four beats (0xA0..0xA3) with rid=2 appear only on m_rvalid[2], m_rlast on beat 4, then IDLE.
- All four m_arvalid held high, len=0 each, s_arready=1 and single-beat responses -> grant order 0,1,2,3,0,1.
- Master 1 burst len=3 with m_rready[1] toggling 1,0,0,1,... -> s_rready mirrors m_rready[1]; all 4 data values are delivered once, in order.
- During master 0's DATA state, drive a beat with s_rid=3 -> beat consumed, no m_rvalid, err_sticky=1. A following correct beat with rid=0 is still delivered.
- rst=1 for one cycle during beat 2 of 4 -> next cycle busy=0, s_arvalid=0, err_sticky=0. With masters 0 and 2 requesting next, master 0 is granted first.
- With ARB_FIXED_PRIORITY_EN, masters 0 and 3 request continuously -> grant_idx stays 0 for 5 consecutive bursts; master 3 is not granted.
